// File: rtl/aes_pkg.sv
// aes_pkg: shared AES key-schedule types, constants and byte/word helpers
package aes_pkg;
  localparam int NR = 10;
  typedef enum logic [1:0] {IDLE, EXPAND, EMIT} state_t;
  localparam logic [7:0] RCON [1:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                          8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  function automatic logic [31:0] word_of(input logic [127:0] k, input int i);
    return k[127-32*i -: 32];
  endfunction
  function automatic logic [31:0] rcon_word(input logic [3:0] r);
    return (r >= 4'd1 && r <= 4'(NR)) ? {RCON[r], 24'h0} : 32'h0;
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = p ^ (b[i] ? x : 8'h00);
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  // S-box as GF(2^8) inverse (x^254, zero maps to zero) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] t, y;
    t = x;
    y = 8'h01;
    for (int i = 0; i < 7; i++) begin
      t = gmul(t, t);
      y = gmul(y, t);
    end
    return y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]} ^ {y[3:0], y[7:4]} ^ 8'h63;
  endfunction
endpackage

// File: rtl/inv_key_sched_key_step.sv
// key_step: one forward or inverse AES-128 key-expansion round sharing a single G
module key_step
  import aes_pkg::*;
(
  input  logic [127:0] i_key,
  input  logic [31:0]  i_rcon,
  input  logic         i_inv,
  output logic [127:0] o_key
);
  logic [31:0] w_k0, w_k1, w_k2, w_k3, w_g, w_n0, w_n1, w_n2;
  assign w_k0 = word_of(i_key, 0);
  assign w_k1 = word_of(i_key, 1);
  assign w_k2 = word_of(i_key, 2);
  assign w_k3 = word_of(i_key, 3);
  // inverse direction recovers the previous word 3 first, then feeds it to G
  operationG u_g (.i_word(i_inv ? w_k2 ^ w_k3 : w_k3), .i_rcon(i_rcon), .o_word(w_g));
  assign w_n0 = w_g ^ w_k0;
  assign w_n1 = w_n0 ^ w_k1;
  assign w_n2 = w_n1 ^ w_k2;
  assign o_key = i_inv ? {w_k0 ^ w_g, w_k0 ^ w_k1, w_k1 ^ w_k2, w_k2 ^ w_k3}
                       : {w_n0, w_n1, w_n2, w_n2 ^ w_k3};
endmodule

// File: rtl/operationG.sv
// operationG: AES key-expansion G function (RotWord, SubWord, XOR rcon)
module operationG
  import aes_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [31:0] i_rcon,
  output logic [31:0] o_word
);
  assign o_word = {sbox(i_word[23:16]), sbox(i_word[15:8]), sbox(i_word[7:0]), sbox(i_word[31:24])} ^ i_rcon;
endmodule

// File: rtl/inv_key_sched.sv
// inv_key_sched: emits AES-128 round keys 10 down to 0 over a valid/ready handshake
module inv_key_sched
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         start,
  input  logic [127:0] cipher_key,
  output logic         busy,
  output logic         key_valid,
  input  logic         key_ready,
  output logic [127:0] key_out,
  output logic [3:0]   key_round,
  output logic         done
);
  state_t       r_state, w_state_nxt;
  logic [127:0] r_key, w_key_nxt, w_step;
  logic [3:0]   r_cnt, w_cnt_nxt;
  logic [31:0]  w_rcon;
  logic         r_done, w_done_nxt;
  // forward steps use rcon of the round being produced, inverse steps that of the current round
  assign w_rcon = rcon_word(r_state == EMIT ? r_cnt : r_cnt + 4'd1);
  key_step u_step (.i_key(r_key), .i_rcon(w_rcon), .i_inv(r_state == EMIT), .o_key(w_step));
  // next-state: expand forward to round NR, then walk back one round per accepted key
  always_comb begin
    w_state_nxt = r_state;
    w_key_nxt = r_key;
    w_cnt_nxt = r_cnt;
    w_done_nxt = 1'b0;
    case (r_state)
      IDLE: if (start) begin
        w_state_nxt = EXPAND;
        w_key_nxt = cipher_key;
        w_cnt_nxt = 4'd0;
      end
      EXPAND: begin
        w_key_nxt = w_step;
        w_cnt_nxt = r_cnt + 4'd1;
        w_state_nxt = (r_cnt == 4'(NR - 1)) ? EMIT : EXPAND;
      end
      EMIT: if (key_ready) begin
        w_state_nxt = (r_cnt == 4'd0) ? IDLE : EMIT;
        w_done_nxt = (r_cnt == 4'd0);
        w_key_nxt = (r_cnt == 4'd0) ? r_key : w_step;
        w_cnt_nxt = (r_cnt == 4'd0) ? r_cnt : r_cnt - 4'd1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end
  // state, key, counter and done registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= IDLE;
      r_key <= '0;
      r_cnt <= '0;
      r_done <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_key <= w_key_nxt;
      r_cnt <= w_cnt_nxt;
      r_done <= w_done_nxt;
    end
  end
  assign busy = (r_state != IDLE);
  assign key_valid = (r_state == EMIT);
  assign key_out = r_key;
  assign key_round = r_cnt;
  assign done = r_done;
endmodule

// File: tb/tb_inv_key_sched.sv
// tb_inv_key_sched: randomized handshake bench against a FIPS-197 word-expansion model
module tb_inv_key_sched;
  logic         clk = 1'b0;
  logic         n_rst, start, key_ready, busy, key_valid, done;
  logic [127:0] cipher_key, key_out;
  logic [3:0]   key_round;
  logic [127:0] exp_rk [0:10];
  logic [127:0] got [0:10];
  logic [7:0]   sb [256];
  int n_pass = 0, n_total = 0;

  inv_key_sched #(.NR(10)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .cipher_key(cipher_key), .busy(busy),
    .key_valid(key_valid), .key_ready(key_ready), .key_out(key_out),
    .key_round(key_round), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // textbook expansion: w[i] = w[i-4] ^ f(w[i-1]) with rcon doubled in GF(2^8)
  task automatic model(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0] rc;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic do_start(input logic [127:0] k);
    cipher_key = k;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_total++;
    if (busy !== 1'b1) $display("FAIL busy_after_start: got %b want 1", busy);
    else n_pass++;
  endtask

  task automatic walk(input logic [127:0] k, input bit rnd, input bit poke, input int stop_at,
                      input bit chain, input logic [127:0] k2);
    int lat, r, guard;
    logic [127:0] pk;
    logic [3:0] pr;
    bit stall;
    model(k);
    lat = 0;
    while (!key_valid && lat < 40) begin
      if (poke && lat == 3) begin
        start = 1'b1;
        cipher_key = {$urandom, $urandom, $urandom, $urandom};
      end
      tick();
      start = 1'b0;
      lat++;
    end
    n_total++;
    if (lat !== 10) $display("FAIL latency: got %0d edges want 10", lat);
    else n_pass++;
    r = 10;
    guard = 0;
    stall = 1'b0;
    pk = '0;
    pr = '0;
    while (r >= 0 && guard < 300) begin
      if (stall) begin
        n_total++;
        if ({key_valid, key_round, key_out} !== {1'b1, pr, pk})
          $display("FAIL stall_hold: got r%0d %h want r%0d %h", key_round, key_out, pr, pk);
        else n_pass++;
      end
      if (r == stop_at && key_valid) begin
        key_ready = 1'b0;
        return;
      end
      key_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (key_valid && key_ready) begin
        n_total++;
        if ({key_round, key_out} !== {4'(r), exp_rk[r]})
          $display("FAIL round_key: got r%0d %h want r%0d %h", key_round, key_out, r, exp_rk[r]);
        else n_pass++;
        got[r] = key_out;
        r--;
      end
      if (poke && r == 6 && key_valid) begin
        start = 1'b1;
        cipher_key = {$urandom, $urandom, $urandom, $urandom};
      end
      stall = key_valid && !key_ready;
      pk = key_out;
      pr = key_round;
      tick();
      start = 1'b0;
      guard++;
    end
    n_total++;
    if (r !== -1) $display("FAIL accept_count: got %0d keys want 11", 10 - r);
    else n_pass++;
    n_total++;
    if ({done, busy, key_valid} !== 3'b100)
      $display("FAIL done_cycle: got done=%b busy=%b valid=%b want 1 0 0", done, busy, key_valid);
    else n_pass++;
    if (chain) begin
      cipher_key = k2;
      start = 1'b1;
    end
    tick();
    start = 1'b0;
    n_total++;
    if ({done, busy} !== {1'b0, chain})
      $display("FAIL done_once: got done=%b busy=%b want 0 %b", done, busy, chain);
    else n_pass++;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    start = 1'b0;
    key_ready = 1'b0;
    cipher_key = '0;
    tick();
    tick();
    n_total++;
    if ({busy, key_valid, done, key_round, key_out} !== '0)
      $display("FAIL reset_state: got busy=%b valid=%b done=%b r%0d %h want all zero",
               busy, key_valid, done, key_round, key_out);
    else n_pass++;
    @(negedge clk);
    n_rst = 1'b1;
    key_ready = 1'b1;
    tick();
    tick();
    n_total++;
    if ({busy, key_valid, done} !== 3'b000)
      $display("FAIL ready_idle: got busy=%b valid=%b done=%b want 0 0 0", busy, key_valid, done);
    else n_pass++;
  endtask

  task automatic test_fips();
    do_start(128'h2b7e151628aed2a6abf7158809cf4f3c);
    walk(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0, 1'b0, -1, 1'b0, '0);
    n_total++;
    if ({got[10], got[9], got[1], got[0]} !== {128'hd014f9a8c9ee2589e13f0cc8b6630ca6,
        128'hac7766f319fadc2128d12941575c006e, 128'ha0fafe1788542cb123a339392a6c7605,
        128'h2b7e151628aed2a6abf7158809cf4f3c})
      $display("FAIL fips_vectors: got r10 %h r9 %h r1 %h r0 %h", got[10], got[9], got[1], got[0]);
    else n_pass++;
  endtask

  task automatic test_stall();
    do_start(128'h2b7e151628aed2a6abf7158809cf4f3c);
    walk(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b1, 1'b0, -1, 1'b0, '0);
  endtask

  task automatic test_ignored_start();
    do_start(128'h2b7e151628aed2a6abf7158809cf4f3c);
    walk(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b1, 1'b1, -1, 1'b0, '0);
  endtask

  task automatic test_async_reset();
    do_start(128'h2b7e151628aed2a6abf7158809cf4f3c);
    walk(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0, 1'b0, 5, 1'b0, '0);
    #2;
    n_rst = 1'b0;
    #1;
    n_total++;
    if ({busy, key_valid, done, key_round, key_out} !== '0)
      $display("FAIL async_reset: got busy=%b valid=%b done=%b r%0d %h want all zero",
               busy, key_valid, done, key_round, key_out);
    else n_pass++;
    @(negedge clk);
    n_rst = 1'b1;
    tick();
    do_start(128'h000102030405060708090a0b0c0d0e0f);
    walk(128'h000102030405060708090a0b0c0d0e0f, 1'b1, 1'b0, -1, 1'b0, '0);
    n_total++;
    if (got[10] !== 128'h13111d7fe3944a17f307a78b4d2b30c5)
      $display("FAIL after_reset_r10: got %h want 13111d7fe3944a17f307a78b4d2b30c5", got[10]);
    else n_pass++;
  endtask

  task automatic test_zero_key();
    do_start('0);
    walk('0, 1'b0, 1'b0, -1, 1'b0, '0);
    n_total++;
    if ({got[10], got[0]} !== {128'hb4ef5bcb3e92e21123e951cf6f8f188e, 128'h0})
      $display("FAIL zero_key: got r10 %h r0 %h", got[10], got[0]);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [127:0] k1, k2;
    k1 = {$urandom, $urandom, $urandom, $urandom};
    k2 = {$urandom, $urandom, $urandom, $urandom};
    do_start(k1);
    walk(k1, 1'b1, 1'b0, -1, 1'b1, k2);
    walk(k2, 1'b1, 1'b0, -1, 1'b0, '0);
  endtask

  task automatic test_random_keys();
    logic [127:0] k;
    for (int i = 0; i < 3; i++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      do_start(k);
      walk(k, 1'b1, 1'b0, -1, 1'b0, '0);
    end
  endtask

  initial begin
    sb = '{
      8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
      8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
      8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
      8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
      8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
      8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
      8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
      8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
      8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
      8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
      8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
      8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
      8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
      8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
      8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
      8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16};
    test_reset();
    test_fips();
    test_stall();
    test_ignored_start();
    test_async_reset();
    test_zero_key();
    test_back_to_back();
    test_random_keys();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
